rps_spi_tx: RTL and testbench

FPGA-to-MCU return path for the rock-paper-scissors link. The block captures a locally sensed gesture (one-hot rock/paper/scissors) and serializes it MSB-first on `sdo`, clocked by the SPI clock. Each frame carries a rolling sequence number, a valid flag and even parity. The MCU decodes frame bits [7:5] with the same bit assignment it uses for the gesture byte it sends to the FPGA.

---
 rtl/rps_pkg.sv | 10 +
 rtl/rps_frame_build.sv | 16 +
 rtl/rps_spi_tx.sv | 75 +++++++
 tb/tb_rps_spi_tx.sv | 90 +++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// rps_pkg: shared gesture encoding and transmitter state type for the rock-paper-scissors link
package rps_pkg;
  localparam int ROCK_B = 2;
  localparam int PAPER_B = 1;
  localparam int SCIS_B = 0;
  localparam logic [2:0] ROCK = 3'b100;
  localparam logic [2:0] PAPER = 3'b010;
  localparam logic [2:0] SCIS = 3'b001;
  typedef enum logic {IDLE, SHIFT} tx_state_t;
endpackage

// File: rtl/rps_frame_build.sv
// rps_frame_build: combinational frame fields; i_gesture, i_seq -> o_valid (one-hot check), o_g (masked gesture), o_par (even parity)
module rps_frame_build
  import rps_pkg::*;
#(
  parameter int SEQ_W = 3
) (
  input  logic [2:0]       i_gesture,
  input  logic [SEQ_W-1:0] i_seq,
  output logic             o_valid,
  output logic [2:0]       o_g,
  output logic             o_par
);
  assign o_valid = (i_gesture == ROCK) | (i_gesture == PAPER) | (i_gesture == SCIS);
  assign o_g = o_valid ? i_gesture : 3'b000;
  assign o_par = ^{o_g, i_seq, o_valid};
endmodule

// File: rtl/rps_spi_tx.sv
// rps_spi_tx: gesture frame serializer; sck, reset (async), start, gesture[2:0] -> sdo (MSB first), busy, done (pulse)
module rps_spi_tx
  import rps_pkg::*;
#(
  parameter int SEQ_W = 3
) (
  input  logic       sck,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] gesture,
  output logic       sdo,
  output logic       busy,
  output logic       done
);
  localparam int FW = 5 + SEQ_W;
  localparam int CW = $clog2(FW);
  tx_state_t r_state, w_nxt_state;
  logic [FW-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic [SEQ_W-1:0] r_seq;
  logic r_sdo, r_busy, r_done;
  logic w_valid, w_par, w_cap, w_last, w_run;
  logic [2:0] w_g;
  logic [FW-1:0] w_frame;
  logic w_sdo, w_busy, w_done;
  rps_frame_build #(.SEQ_W(SEQ_W)) u_build (
    .i_gesture(gesture),
    .i_seq    (r_seq),
    .o_valid  (w_valid),
    .o_g      (w_g),
    .o_par    (w_par)
  );
  assign w_frame = {w_g, r_seq, w_valid, w_par};
  assign w_cap = (r_state == IDLE) && start;
  assign w_last = (r_state == SHIFT) && (r_cnt == '0);
  assign w_run = (r_state == SHIFT) && !w_last;
  always_ff @(posedge sck or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_nxt_state;
  end
  always_comb begin
    w_nxt_state = w_cap ? SHIFT : w_last ? IDLE : r_state;
  end
  // r_shift holds only the bits not yet on sdo, MSB-aligned
  always_comb begin
    w_sdo = w_cap ? w_frame[FW-1] : w_run ? r_shift[FW-1] : 1'b0;
    w_busy = w_cap | w_run;
    w_done = w_last;
  end
  always_ff @(posedge sck or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt <= '0;
      r_seq <= '0;
      r_sdo <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_sdo <= w_sdo;
      r_busy <= w_busy;
      r_done <= w_done;
      if (w_cap) begin
        r_shift <= {w_frame[FW-2:0], 1'b0};
        r_cnt <= CW'(FW - 1);
      end else if (w_run) begin
        r_shift <= {r_shift[FW-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_last) r_seq <= r_seq + 1'b1;
    end
  end
  assign sdo = r_sdo;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_rps_spi_tx.sv
// tb_rps_spi_tx: directed frame checks for rps_spi_tx
module tb_rps_spi_tx;
  logic sck = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] gesture = 3'b000;
  logic sdo, busy, done;
  int total = 0;
  int bad = 0;
  logic [7:0] wrap_exp [9] = '{8'h8E, 8'h93, 8'h96, 8'h9A, 8'h9F, 8'h82, 8'h87, 8'h8B, 8'h8E};
  rps_spi_tx #(.SEQ_W(3)) dut (
    .sck    (sck),
    .reset  (reset),
    .start  (start),
    .gesture(gesture),
    .sdo    (sdo),
    .busy   (busy),
    .done   (done)
  );
  always #5 sck = ~sck;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [2:0] g, input logic [7:0] exp, input bit hold, input bit toggle, input string tag);
    logic [7:0] bits;
    int nb;
    bit dn;
    bits = '0;
    nb = 0;
    dn = 1'b0;
    start = 1'b1;
    gesture = g;
    for (int i = 0; i < 8; i++) begin
      @(negedge sck);
      bits = {bits[6:0], sdo};
      nb += int'(busy);
      dn |= done;
      if (i == 0) start = hold;
      if (toggle && i == 2) gesture = ~g;
    end
    chk({tag, "_frame"}, bits, exp);
    chk({tag, "_busy_cycles"}, nb, 8);
    chk({tag, "_early_done"}, dn, 0);
    @(negedge sck);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_sdo_end"}, sdo, 0);
  endtask
  initial begin
    @(negedge sck);
    chk("rst_sdo", sdo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge sck);
    send(3'b100, 8'h82, 1'b0, 1'b0, "rock");
    send(3'b010, 8'h47, 1'b0, 1'b0, "paper_b2b");
    send(3'b110, 8'h09, 1'b0, 1'b0, "invalid");
    for (int k = 0; k < 9; k++) send(3'b100, wrap_exp[k], k != 8, 1'b0, $sformatf("wrap%0d", k));
    @(negedge sck);
    chk("idle_done_clear", done, 0);
    start = 1'b1;
    gesture = 3'b100;
    for (int i = 0; i < 4; i++) begin
      @(negedge sck);
      start = 1'b0;
    end
    chk("pre_rst_sdo", sdo, 1);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_sdo", sdo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge sck);
    reset = 1'b0;
    @(negedge sck);
    chk("abort_no_done", done, 0);
    send(3'b001, 8'h22, 1'b0, 1'b0, "post_rst");
    send(3'b010, 8'h47, 1'b0, 1'b1, "toggle");
    @(negedge sck);
    chk("final_idle_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
